// File: rtl/graphics_draw_controller_pkg.sv
// Shared types and constants for the 8x8-block draw controller.
package graphics_draw_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DRAW = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int         BLOCK_SIDE = 8;
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_WHITE  = 3'b111;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] col;
    logic       fl;
  } blk_req_t;

endpackage

// File: rtl/graphics_draw_controller_rr_arbiter.sv
// Two-way round-robin arbiter; the favoured-requester pointer is owned by the caller.
module graphics_draw_controller_rr_arbiter (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = ptr_i ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/graphics_draw_controller.sv
// Block-draw sequencer: arbitrates two requesters and strobes the 8x8 datapath
// and VGA plot enable for one 64-pixel block per grant.
module graphics_draw_controller
  import graphics_draw_controller_pkg::*;
#(
  parameter int BLOCK_PIXELS = 64,
  parameter int CNT_W        = 6
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic [7:0] req_x0,
  input  logic [7:0] req_y0,
  input  logic [2:0] req_col0,
  input  logic       req_fl0,
  input  logic [7:0] req_x1,
  input  logic [7:0] req_y1,
  input  logic [2:0] req_col1,
  input  logic       req_fl1,
  output logic [1:0] ack,
  output logic [7:0] dp_x,
  output logic [7:0] dp_y,
  output logic [2:0] dp_colour,
  output logic       dp_load,
  output logic       dp_enable,
  output logic       dp_flash,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_PIXELS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ptr_q, gidx_q;
  logic [1:0]       ack_q;
  blk_req_t         blk_q;
  logic             load_q, en_q, plot_q, busy_q, done_q;

  logic [1:0] grant;
  blk_req_t   sel;

  graphics_draw_controller_rr_arbiter u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign sel = grant[1] ? '{x: req_x1, y: req_y1, col: req_col1, fl: req_fl1}
                        : '{x: req_x0, y: req_y0, col: req_col0, fl: req_fl0};

  // Every strobe is registered on the transition into the state it belongs to,
  // so the outputs line up with state_q without any decode glitches.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      gidx_q  <= 1'b0;
      ack_q   <= 2'b00;
      blk_q   <= '{x: 8'd0, y: 8'd0, col: COL_BLACK, fl: 1'b0};
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        ST_IDLE: if (|req) begin
          state_q <= ST_LOAD;
          blk_q   <= sel;
          ack_q   <= grant;
          gidx_q  <= grant[1];
          load_q  <= 1'b1;
          en_q    <= 1'b1;
          busy_q  <= 1'b1;
        end
        ST_LOAD: begin
          state_q <= ST_DRAW;
          cnt_q   <= '0;
          ptr_q   <= ~gidx_q;
          load_q  <= 1'b0;
          plot_q  <= 1'b1;
        end
        ST_DRAW: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            en_q    <= 1'b0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign dp_x      = blk_q.x;
  assign dp_y      = blk_q.y;
  assign dp_colour = blk_q.col;
  assign dp_flash  = blk_q.fl;
  assign dp_load   = load_q;
  assign dp_enable = en_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_graphics_draw_controller.sv
// Scoreboard bench: stimulus queues expected acks/pixels, a monitor compares them.
module tb_graphics_draw_controller;

  logic       clock = 1'b0;
  logic       resetn;
  logic [1:0] req;
  logic [7:0] req_x0, req_y0, req_x1, req_y1;
  logic [2:0] req_col0, req_col1;
  logic       req_fl0, req_fl1;
  logic [1:0] ack;
  logic [7:0] dp_x, dp_y;
  logic [2:0] dp_colour;
  logic       dp_load, dp_enable, dp_flash, plot, busy, done;

  always #5 clock = ~clock;

  graphics_draw_controller dut (
    .clock(clock), .resetn(resetn), .req(req),
    .req_x0(req_x0), .req_y0(req_y0), .req_col0(req_col0), .req_fl0(req_fl0),
    .req_x1(req_x1), .req_y1(req_y1), .req_col1(req_col1), .req_fl1(req_fl1),
    .ack(ack), .dp_x(dp_x), .dp_y(dp_y), .dp_colour(dp_colour),
    .dp_load(dp_load), .dp_enable(dp_enable), .dp_flash(dp_flash),
    .plot(plot), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t       pix_q[$];
  logic [1:0] ack_q[$];
  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int k    = 0;
  int ack_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: external datapath model (x0 + k[5:3], y0 + k[2:0], flash forces white).
  always @(negedge clock) begin
    if (!resetn) begin
      k = 0;
    end else begin
      if (ack != 2'b00) begin
        if (ack_q.size() == 0) chk("unexpected_ack", {30'd0, ack}, 32'd0);
        else chk("ack", {30'd0, ack}, {30'd0, ack_q.pop_front()});
        k = 0;
        ack_cyc = cyc;
      end
      if (plot) begin
        logic [5:0] kk;
        pix_t act, exp;
        kk = k[5:0];
        act.x = dp_x + {5'd0, kk[5:3]};
        act.y = dp_y + {5'd0, kk[2:0]};
        act.c = dp_flash ? 3'b111 : dp_colour;
        if (pix_q.size() == 0) chk("unexpected_plot", 32'd1, 32'd0);
        else begin
          exp = pix_q.pop_front();
          chk("pixel", {13'd0, act}, {13'd0, exp});
        end
        if (k == 0) chk("first_plot_latency", cyc - ack_cyc, 32'd1);
        if (dp_load || done || !busy || !dp_enable) chk("plot_outside_draw", 32'd1, 32'd0);
        k++;
      end
      if (done) begin
        chk("done_pixel_count", k, 32'd64);
        chk("done_latency", cyc - ack_cyc, 32'd65);
        if (busy) chk("done_with_busy", 32'd1, 32'd0);
      end
    end
  end

  task automatic push_block(input logic [1:0] a, input logic [7:0] x, input logic [7:0] y,
                            input logic [2:0] c, input logic fl);
    ack_q.push_back(a);
    for (int i = 0; i < 64; i++) begin
      logic [5:0] kk;
      pix_t p;
      kk  = 6'(i);
      p.x = x + {5'd0, kk[5:3]};
      p.y = y + {5'd0, kk[2:0]};
      p.c = fl ? 3'b111 : c;
      pix_q.push_back(p);
    end
  endtask

  task automatic wait_ack(input int id);
    bit seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clock);
      if (ack[id]) seen = 1;
    end
    if (!seen) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic set0(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c, input logic fl);
    req_x0 = x; req_y0 = y; req_col0 = c; req_fl0 = fl;
  endtask

  task automatic set1(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c, input logic fl);
    req_x1 = x; req_y1 = y; req_col1 = c; req_fl1 = fl;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    req    = 2'b00;
    set0(8'd0, 8'd0, 3'b000, 1'b0);
    set1(8'd0, 8'd0, 3'b000, 1'b0);
    repeat (3) @(negedge clock);
    chk("reset_outputs", {ack, dp_x, dp_y, dp_colour, dp_load, dp_enable, dp_flash, plot, busy, done}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // 1: single requester 0
    set0(8'd10, 8'd20, 3'b100, 1'b0);
    push_block(2'b01, 8'd10, 8'd20, 3'b100, 1'b0);
    req = 2'b01;
    wait_ack(0);
    req = 2'b00;
    chk("t1_dp_load_at_ack", {31'd0, dp_load}, 32'd1);
    chk("t1_busy_at_ack", {31'd0, busy}, 32'd1);
    chk("t1_no_plot_at_ack", {31'd0, plot}, 32'd0);
    wait_done();

    // 2: both request; pointer was moved to 1 by block 1, so req1 wins first here
    set0(8'd30, 8'd40, 3'b001, 1'b0);
    set1(8'd50, 8'd60, 3'b011, 1'b0);
    push_block(2'b10, 8'd50, 8'd60, 3'b011, 1'b0);
    push_block(2'b01, 8'd30, 8'd40, 3'b001, 1'b0);
    req = 2'b11;
    wait_ack(1);
    req[1] = 1'b0;
    wait_ack(0);
    req[0] = 1'b0;
    wait_done();
    // pointer now favours 1 again -> alternation
    push_block(2'b10, 8'd50, 8'd60, 3'b011, 1'b0);
    push_block(2'b01, 8'd30, 8'd40, 3'b001, 1'b0);
    req = 2'b11;
    wait_ack(1);
    req[1] = 1'b0;
    wait_ack(0);
    req[0] = 1'b0;
    wait_done();

    // 3: flash on requester 1
    set1(8'd5, 8'd6, 3'b010, 1'b1);
    push_block(2'b10, 8'd5, 8'd6, 3'b010, 1'b1);
    req = 2'b10;
    wait_ack(1);
    req = 2'b00;
    chk("t3_dp_colour", {29'd0, dp_colour}, 32'd2);
    chk("t3_dp_flash", {31'd0, dp_flash}, 32'd1);
    wait_done();

    // 4: coordinate wrap
    set0(8'd252, 8'd250, 3'b110, 1'b0);
    push_block(2'b01, 8'd252, 8'd250, 3'b110, 1'b0);
    req = 2'b01;
    wait_ack(0);
    req = 2'b00;
    wait_done();

    // 6: requester inputs change mid-draw
    set0(8'd40, 8'd60, 3'b101, 1'b0);
    push_block(2'b01, 8'd40, 8'd60, 3'b101, 1'b0);
    req = 2'b01;
    wait_ack(0);
    req = 2'b00;
    repeat (10) @(negedge clock);
    set0(8'd99, 8'd5, 3'b011, 1'b1);
    wait_done();
    chk("t6_dp_x_held", {24'd0, dp_x}, 32'd40);

    // 5: reset during pixel 30; req0 served first so pointer favours 1 before reset
    set0(8'd10, 8'd20, 3'b100, 1'b0);
    push_block(2'b01, 8'd10, 8'd20, 3'b100, 1'b0);
    req = 2'b01;
    wait_ack(0);
    req = 2'b00;
    repeat (31) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("t5_plot_after_reset", {31'd0, plot}, 32'd0);
    chk("t5_busy_after_reset", {31'd0, busy}, 32'd0);
    chk("t5_done_after_reset", {31'd0, done}, 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    pix_q.delete();
    ack_q.delete();
    repeat (5) @(negedge clock);
    chk("t5_idle_no_done", {31'd0, done}, 32'd0);
    set0(8'd1, 8'd2, 3'b111, 1'b0);
    set1(8'd3, 8'd4, 3'b001, 1'b0);
    push_block(2'b01, 8'd1, 8'd2, 3'b111, 1'b0);
    push_block(2'b10, 8'd3, 8'd4, 3'b001, 1'b0);
    req = 2'b11;
    wait_ack(0);
    req[0] = 1'b0;
    wait_ack(1);
    req[1] = 1'b0;
    wait_done();

    repeat (4) @(negedge clock);
    chk("pix_queue_empty", pix_q.size(), 32'd0);
    chk("ack_queue_empty", ack_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
